nerv_wb_bridge: RTL and testbench
=================================

# nerv_wb_bridge

Sequencing bridge between the nerv core's single-cycle memory ports and the two Wishbone masters (`core_*` instruction bus, `data_mem_*` data bus) consumed by the Controller. It captures each core step's fetch and optional data access and runs them as concurrent Wishbone transactions. It holds the core on `stall` until both transactions complete, then presents the captured read data. This replaces the hard-tied `stall=0` and ack-delay registers in the top wrapper with a real handshake, so memories of any latency are supported.

## Interface
- `IMEM_RESET_DATA`, default 32'h0000_0013: `imem_data` value from reset until the first fetch completes (NOP).
- `DMEM_RESET_DATA`, default 32'h0000_0000: `dmem_rdata` value from reset until the first data read completes.
- `clk_core` input 1: core clock; all state changes on its rising edge.
- `rst_core` input 1: reset, asynchronous and active-high.
- `imem_addr` input 32: core fetch address; one fetch request every step.
- `imem_data` output 32: fetched instruction word for the previous step.
- `dmem_valid` input 1: core data access request this step.
- `dmem_addr` input 32: data address.
- `dmem_wstrb` input 4: byte write strobes; 0 means read.
- `dmem_wdata` input 32: write data.
- `dmem_rdata` output 32: read data for the previous step's data read.
- `stall` output 1: freezes the core while high.
- `core_cyc`, `core_stb`, `core_we` output 1 each: instruction Wishbone controls. `core_we` is always 0.
- `core_sel` output 4, `core_addr` output 32, `core_data_out` output 32: instruction bus. `core_sel`=4'b1111, `core_data_out`=0.
- `core_data_in` input 32, `core_ack` input 1: instruction bus response.
- `data_mem_cyc`, `data_mem_stb`, `data_mem_we` output 1 each; `data_mem_sel` output 4; `data_mem_addr` output 32; `data_mem_data_out` output 32: data bus request.
- `data_mem_data_in` input 32, `data_mem_ack` input 1: data bus response.

## Operation
- States: STEP and WAIT.
- STEP:
  - `stall`=0.
  - At the clock edge, capture the request:
    - Instruction address: `{imem_addr[31:2],2'b00}`.
    - If `dmem_valid`: `{dmem_addr[31:2],2'b00}`, `dmem_wstrb`, `dmem_wdata`.
  - Set `i_pend`=1 and `d_pend`=`dmem_valid`.
  - Go to WAIT.
- WAIT:
  - `stall`=1.
  - `core_cyc`=`i_pend`. `data_mem_cyc`=`d_pend`.
  - Data bus qualifiers: `data_mem_we`=|wstrb. `data_mem_sel`=wstrb on writes, 4'b1111 on reads.
  - An ack is honoured only while the matching `cyc` is high.
  - On `core_ack`: latch `core_data_in` into `imem_data` and clear `i_pend`.
  - On `data_mem_ack` for a read: latch `data_mem_data_in` into `dmem_rdata`. Any ack clears `d_pend`. Writes leave `dmem_rdata` unchanged.
  - Each bus drops `cyc`/`stb` in the cycle after its own ack, independently of the other bus.
  - When both pend flags are clear at the edge (including acks in that same cycle), go to STEP.
- `imem_data` and `dmem_rdata` are stable at all times except on the latching edge.
- Acks arriving while `cyc` is low are ignored.
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to STEP; pend flags clear.
  - All `cyc`/`stb`/`we` = 0, `sel`/`addr`/`data_out` = 0, `stall`=0.
  - `imem_data`=`IMEM_RESET_DATA`, `dmem_rdata`=`DMEM_RESET_DATA`.
  - Any outstanding bus transaction is abandoned.

## Timing
- STEP always lasts exactly 1 cycle.
- WAIT lasts max(instruction latency, data latency) cycles, minimum 1.
- Ack asserted combinationally in the first WAIT cycle gives 2 cycles per core step.
- With registered slaves (ack one cycle after `stb`), it is 3 cycles per step.
- Captured data appears on `imem_data`/`dmem_rdata` in the cycle `stall` falls, i.e. the STEP cycle.
- Bus outputs are registered; no combinational path exists from core inputs to Wishbone outputs.

## Configuration
- `NERV_WB_PIPELINED_EN` defined: pipelined Wishbone.
  - `stb` is high only in the first WAIT cycle of each bus; `cyc` stays high until ack.
  - Acks may arrive any cycle from the first WAIT cycle onward.
- Not defined: classic Wishbone.
  - `stb` equals `cyc` and stays high until ack.
- Core-side behaviour and state sequence are identical in both modes.

## Test plan
- **Fetch only, zero-wait slave.** `imem_addr`=0x104, `dmem_valid`=0, `core_ack` combinational with `core_data_in`=0x00500093.
  - Expect `core_addr`=0x104 for 1 cycle and `stall` high for 1 cycle.
  - Expect `imem_data`=0x00500093 in the following STEP.
  - Expect `data_mem_cyc` never asserted.
- **Unaligned write.** `dmem_addr`=0x2003, `dmem_wstrb`=4'b1000, `dmem_wdata`=0xAB000000.
  - Expect `data_mem_addr`=0x2000, `data_mem_we`=1, `data_mem_sel`=4'b1000.
  - Expect `dmem_rdata` unchanged.
- **Skewed latencies.** Instruction ack after 1 cycle, data read ack after 4 cycles returning 0xCAFEF00D.
  - Expect `core_cyc` low from cycle 2 and `stall` high for 4 cycles.
  - Expect `dmem_rdata`=0xCAFEF00D when `stall` falls.
- **Simultaneous acks.** Both acks in the same WAIT cycle.
  - Expect a single transition to STEP and both data words latched.
- **Mode check.** 3-cycle slave.
  - Classic build: `stb` high for 3 cycles.
  - `NERV_WB_PIPELINED_EN` build: `stb` high for 1 cycle, `cyc` for 3.
- **Reset mid-WAIT, then stray ack.** Assert `rst_core` mid-WAIT.
  - Expect all bus outputs 0, `stall`=0 and `imem_data`=0x00000013 immediately, without a clock edge.
  - A late `core_ack` after release is ignored.

Source files
------------

// File: rtl/nerv_wb_bridge.sv
// Sequences each nerv core step into concurrent Wishbone fetch and data transactions, stalling the core until both finish.
// Define NERV_WB_PIPELINED_EN for pipelined Wishbone (single-cycle stb); otherwise classic Wishbone (stb follows cyc).
module nerv_wb_bridge #(
   parameter logic [31:0] IMEM_RESET_DATA = 32'h0000_0013,
   parameter logic [31:0] DMEM_RESET_DATA = 32'h0000_0000
) (
   input  logic        clk_core,
   input  logic        rst_core,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_wstrb,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        core_cyc,
   output logic        core_stb,
   output logic        core_we,
   output logic [3:0]  core_sel,
   output logic [31:0] core_addr,
   output logic [31:0] core_data_out,
   input  logic [31:0] core_data_in,
   input  logic        core_ack,
   output logic        data_mem_cyc,
   output logic        data_mem_stb,
   output logic        data_mem_we,
   output logic [3:0]  data_mem_sel,
   output logic [31:0] data_mem_addr,
   output logic [31:0] data_mem_data_out,
   input  logic [31:0] data_mem_data_in,
   input  logic        data_mem_ack,
   output logic        dbg_state_o
);

   typedef enum logic {ST_STEP = 1'b0, ST_WAIT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d;
   logic        i_stb_q, i_stb_d, d_stb_q, d_stb_d;
   logic [31:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
   logic [3:0]  d_wstrb_q, d_wstrb_d;
   logic [31:0] d_wdata_q, d_wdata_d;
   logic [31:0] imem_data_q, imem_data_d, dmem_rdata_q, dmem_rdata_d;
   logic        i_ack, d_ack, d_write;

   // Acks only count while the matching cycle is open; stray acks are dropped.
   assign i_ack   = core_ack & i_pend_q;
   assign d_ack   = data_mem_ack & d_pend_q;
   assign d_write = |d_wstrb_q;

   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         state_q      <= ST_STEP;
         i_pend_q     <= 1'b0;
         d_pend_q     <= 1'b0;
         i_stb_q      <= 1'b0;
         d_stb_q      <= 1'b0;
         i_addr_q     <= 32'h0;
         d_addr_q     <= 32'h0;
         d_wstrb_q    <= 4'h0;
         d_wdata_q    <= 32'h0;
         imem_data_q  <= IMEM_RESET_DATA;
         dmem_rdata_q <= DMEM_RESET_DATA;
      end else begin
         state_q      <= state_d;
         i_pend_q     <= i_pend_d;
         d_pend_q     <= d_pend_d;
         i_stb_q      <= i_stb_d;
         d_stb_q      <= d_stb_d;
         i_addr_q     <= i_addr_d;
         d_addr_q     <= d_addr_d;
         d_wstrb_q    <= d_wstrb_d;
         d_wdata_q    <= d_wdata_d;
         imem_data_q  <= imem_data_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      i_pend_d     = i_pend_q;
      d_pend_d     = d_pend_q;
      i_stb_d      = i_stb_q;
      d_stb_d      = d_stb_q;
      i_addr_d     = i_addr_q;
      d_addr_d     = d_addr_q;
      d_wstrb_d    = d_wstrb_q;
      d_wdata_d    = d_wdata_q;
      imem_data_d  = imem_data_q;
      dmem_rdata_d = dmem_rdata_q;
      case (state_q)
         ST_STEP: begin
            i_addr_d = {imem_addr[31:2], 2'b00};
            if (dmem_valid) begin
               d_addr_d  = {dmem_addr[31:2], 2'b00};
               d_wstrb_d = dmem_wstrb;
               d_wdata_d = dmem_wdata;
            end
            i_pend_d = 1'b1;
            d_pend_d = dmem_valid;
            i_stb_d  = 1'b1;
            d_stb_d  = dmem_valid;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            i_stb_d = 1'b0;
            d_stb_d = 1'b0;
            if (i_ack) begin
               imem_data_d = core_data_in;
               i_pend_d    = 1'b0;
            end
            if (d_ack) begin
               if (!d_write) dmem_rdata_d = data_mem_data_in;
               d_pend_d = 1'b0;
            end
            if (!i_pend_d && !d_pend_d) state_d = ST_STEP;
         end
         default: state_d = ST_STEP;
      endcase
   end

   assign stall       = (state_q == ST_WAIT);
   assign dbg_state_o = state_q;
   assign imem_data   = imem_data_q;
   assign dmem_rdata  = dmem_rdata_q;

   assign core_cyc      = i_pend_q;
   assign core_we       = 1'b0;
   assign core_sel      = {4{i_pend_q}};
   assign core_addr     = i_addr_q;
   assign core_data_out = 32'h0;

   assign data_mem_cyc      = d_pend_q;
   assign data_mem_we       = d_pend_q & d_write;
   assign data_mem_sel      = !d_pend_q ? 4'h0 : (d_write ? d_wstrb_q : 4'hF);
   assign data_mem_addr     = d_addr_q;
   assign data_mem_data_out = d_wdata_q;

`ifdef NERV_WB_PIPELINED_EN
   assign core_stb     = i_pend_q & i_stb_q;
   assign data_mem_stb = d_pend_q & d_stb_q;
`else
   assign core_stb     = i_pend_q;
   assign data_mem_stb = d_pend_q;
`endif

endmodule

// File: tb/tb_nerv_wb_bridge.sv
// Directed bench for nerv_wb_bridge: scripted slave latencies, scoreboard of latched words per core step.
module tb_nerv_wb_bridge;

   logic        clk_core = 1'b0;
   logic        rst_core;
   logic [31:0] imem_addr, imem_data;
   logic        dmem_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        stall;
   logic        core_cyc, core_stb, core_we, core_ack;
   logic [3:0]  core_sel;
   logic [31:0] core_addr, core_data_out, core_data_in;
   logic        data_mem_cyc, data_mem_stb, data_mem_we, data_mem_ack;
   logic [3:0]  data_mem_sel;
   logic [31:0] data_mem_addr, data_mem_data_out, data_mem_data_in;
   logic        dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_dmem;

   nerv_wb_bridge dut (
      .clk_core(clk_core), .rst_core(rst_core),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .stall(stall),
      .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
      .core_addr(core_addr), .core_data_out(core_data_out),
      .core_data_in(core_data_in), .core_ack(core_ack),
      .data_mem_cyc(data_mem_cyc), .data_mem_stb(data_mem_stb), .data_mem_we(data_mem_we),
      .data_mem_sel(data_mem_sel), .data_mem_addr(data_mem_addr),
      .data_mem_data_out(data_mem_data_out), .data_mem_data_in(data_mem_data_in),
      .data_mem_ack(data_mem_ack), .dbg_state_o(dbg_state)
   );

   // Clock
   always #5 clk_core = ~clk_core;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one core step from a STEP cycle (called at #1 after an edge) through the following WAIT.
   task automatic do_step(input logic [31:0] ia, input logic dv, input logic [31:0] da,
                          input logic [3:0] ws, input logic [31:0] wd,
                          input int ilat, input int dlat,
                          input logic [31:0] idata, input logic [31:0] ddata, input logic stray);
      int c, n_stall, n_icyc, n_istb, n_dcyc, n_dstb, act_d;
      logic [31:0] e_i, e_d;
      check("step_stall_low", {31'h0, stall}, 32'h0);
      imem_addr = ia; dmem_valid = dv; dmem_addr = da; dmem_wstrb = ws; dmem_wdata = wd;
      exp_q.push_back(idata);
      if (dv && ws == 4'h0) m_dmem = ddata;
      exp_q.push_back(m_dmem);
      @(posedge clk_core); #1;
      dmem_valid = 1'b0;
      check("core_addr", core_addr, {ia[31:2], 2'b00});
      check("core_sel", {28'h0, core_sel}, 32'hF);
      check("core_we", {31'h0, core_we}, 32'h0);
      if (dv) begin
         check("dm_addr", data_mem_addr, {da[31:2], 2'b00});
         check("dm_we", {31'h0, data_mem_we}, {31'h0, |ws});
         check("dm_sel", {28'h0, data_mem_sel}, (ws != 4'h0) ? {28'h0, ws} : 32'hF);
         check("dm_dout", data_mem_data_out, wd);
      end
      c = 1; n_stall = 0; n_icyc = 0; n_istb = 0; n_dcyc = 0; n_dstb = 0;
      while (stall === 1'b1 && c <= 20) begin
         n_stall++;
         if (core_cyc) n_icyc++;
         if (core_stb) n_istb++;
         if (data_mem_cyc) n_dcyc++;
         if (data_mem_stb) n_dstb++;
         core_ack = (c == ilat) || (stray && c > ilat);
         core_data_in = (c == ilat) ? idata : 32'hDEAD_BEEF;
         data_mem_ack = dv && (c == dlat);
         data_mem_data_in = (c == dlat) ? ddata : 32'hBAD0_BAD0;
         @(posedge clk_core); #1;
         core_ack = 1'b0; data_mem_ack = 1'b0;
         c++;
      end
      if (stall === 1'b1) begin
         n_cmp++; n_err++;
         $error("FAIL wait_timeout: stall still %b after 20 cycles, expected 0", stall);
      end
      act_d = dv ? dlat : 0;
      check("stall_cycles", n_stall, (ilat > act_d) ? ilat : act_d);
      check("core_cyc_cycles", n_icyc, ilat);
      check("dm_cyc_cycles", n_dcyc, act_d);
`ifdef NERV_WB_PIPELINED_EN
      check("core_stb_cycles", n_istb, 1);
      check("dm_stb_cycles", n_dstb, dv ? 1 : 0);
`else
      check("core_stb_cycles", n_istb, ilat);
      check("dm_stb_cycles", n_dstb, act_d);
`endif
      check("step_core_cyc", {31'h0, core_cyc}, 32'h0);
      e_i = exp_q.pop_front();
      e_d = exp_q.pop_front();
      check("imem_data", imem_data, e_i);
      check("dmem_rdata", dmem_rdata, e_d);
   endtask

   initial begin
      rst_core = 1'b1;
      imem_addr = 32'h0; dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wstrb = 4'h0; dmem_wdata = 32'h0;
      core_ack = 1'b0; core_data_in = 32'h0; data_mem_ack = 1'b0; data_mem_data_in = 32'h0;
      m_dmem = 32'h0;
      #2;
      check("rst_imem_data", imem_data, 32'h0000_0013);
      check("rst_dmem_rdata", dmem_rdata, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_core_cyc", {31'h0, core_cyc}, 32'h0);
      check("rst_dm_cyc", {31'h0, data_mem_cyc}, 32'h0);
      @(posedge clk_core); #1;
      rst_core = 1'b0;

      // Fetch only, zero-wait
      do_step(32'h104, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h0050_0093, 32'h0, 1'b0);
      // Unaligned byte write
      do_step(32'h108, 1'b1, 32'h2003, 4'b1000, 32'hAB00_0000, 1, 2, 32'h0000_0113, 32'h0, 1'b0);
      // Skewed latencies with stray instruction acks after the fetch completes
      do_step(32'h10C, 1'b1, 32'h3000, 4'h0, 32'h0, 1, 4, 32'h0000_0213, 32'hCAFE_F00D, 1'b1);
      // Simultaneous acks
      do_step(32'h110, 1'b1, 32'h3004, 4'h0, 32'h0, 2, 2, 32'h0000_0313, 32'h1234_5678, 1'b0);
      // Three-cycle slaves on both buses
      do_step(32'h114, 1'b1, 32'h3008, 4'h0, 32'h0, 3, 3, 32'h0000_0413, 32'h8765_4321, 1'b0);
      // Write after a read leaves read data alone; instruction slower than data
      do_step(32'h118, 1'b1, 32'h300D, 4'b0011, 32'h0000_BEEF, 4, 1, 32'h0000_0513, 32'h0, 1'b0);
      // Random latencies and request mix
      for (int k = 0; k < 6; k++) begin
         do_step(32'h200 + 4 * k, 1'($urandom_range(0, 1)), 32'h4000 + $urandom_range(0, 255),
                 ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom,
                 $urandom_range(1, 4), $urandom_range(1, 4), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      // Reset mid-WAIT, then stray ack while cyc is low
      imem_addr = 32'h300; dmem_valid = 1'b1; dmem_addr = 32'h400; dmem_wstrb = 4'h0;
      @(posedge clk_core); #1;
      dmem_valid = 1'b0;
      check("pre_rst_core_cyc", {31'h0, core_cyc}, 32'h1);
      #2 rst_core = 1'b1;
      #1;
      check("mid_rst_core_cyc", {31'h0, core_cyc}, 32'h0);
      check("mid_rst_core_stb", {31'h0, core_stb}, 32'h0);
      check("mid_rst_core_addr", core_addr, 32'h0);
      check("mid_rst_core_sel", {28'h0, core_sel}, 32'h0);
      check("mid_rst_dm_cyc", {31'h0, data_mem_cyc}, 32'h0);
      check("mid_rst_dm_stb", {31'h0, data_mem_stb}, 32'h0);
      check("mid_rst_dm_we", {31'h0, data_mem_we}, 32'h0);
      check("mid_rst_dm_sel", {28'h0, data_mem_sel}, 32'h0);
      check("mid_rst_dm_addr", data_mem_addr, 32'h0);
      check("mid_rst_stall", {31'h0, stall}, 32'h0);
      check("mid_rst_imem_data", imem_data, 32'h0000_0013);
      check("mid_rst_dmem_rdata", dmem_rdata, 32'h0);
      @(posedge clk_core); #1;
      rst_core = 1'b0;
      m_dmem = 32'h0;
      core_ack = 1'b1; core_data_in = 32'hDEAD_BEEF;
      @(posedge clk_core); #1;
      core_ack = 1'b0;
      check("stray_imem_data", imem_data, 32'h0000_0013);
      check("post_rst_stall", {31'h0, stall}, 32'h1);
      core_ack = 1'b1; core_data_in = 32'h0010_0073;
      @(posedge clk_core); #1;
      core_ack = 1'b0;
      check("post_rst_step", {31'h0, stall}, 32'h0);
      check("post_rst_imem_data", imem_data, 32'h0010_0073);
      check("post_rst_dmem_rdata", dmem_rdata, m_dmem);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
